// File: rtl/cl_ocl_axil_master_if.sv
// AXI-Lite bus bundle between the OCL initiator (master) and a register-mapped CL slave.
interface cl_ocl_axil_master_if;
   logic        m_awvalid;
   logic        m_awready;
   logic [31:0] m_awaddr;
   logic        m_wvalid;
   logic        m_wready;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_bvalid;
   logic        m_bready;
   logic [1:0]  m_bresp;
   logic        m_arvalid;
   logic        m_arready;
   logic [31:0] m_araddr;
   logic        m_rvalid;
   logic        m_rready;
   logic [31:0] m_rdata;
   logic [1:0]  m_rresp;

   modport master (
      output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_rready,
      input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid,
             m_rdata, m_rresp
   );

   modport slave (
      input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
             m_arvalid, m_araddr, m_rready,
      output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid,
             m_rdata, m_rresp
   );
endinterface

// File: rtl/cl_ocl_axil_master.sv
// Single-outstanding AXI-Lite initiator: command/response handshake in, 32-bit
// single-beat reads/writes out, with a non-aborting watchdog and sticky error status.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_REQ  | AW and W presented independently until both handshakes done
// ST_WR_RESP | m_bready high, waiting for the write response
// ST_RD_REQ  | AR presented, waiting for m_arready
// ST_RD_DATA | m_rready high, waiting for read data
// ST_RSP     | rsp_valid high, holding the response until rsp_ready
module cl_ocl_axil_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                 clk_main_a0,
   input  logic                 rst_main_n,

   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_wr,
   input  logic [31:0]          cmd_addr,
   input  logic [31:0]          cmd_wdata,
   input  logic [3:0]           cmd_wstrb,

   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_rdata,
   output logic [1:0]           rsp_resp,
   output logic                 rsp_wr,

   cl_ocl_axil_master_if.master axil,

   output logic                 timeout_sticky,
   output logic                 err_sticky,
   input  logic                 sticky_clr,
   output logic [CNT_W-1:0]     done_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_DATA = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            state_nxt;

   logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, rsp_valid_q;
   logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, rsp_valid_d;
   logic [31:0]       awaddr_q, wdata_q, araddr_q, rsp_rdata_q;
   logic [3:0]        wstrb_q;
   logic [1:0]        rsp_resp_q;
   logic              rsp_wr_q;
   logic              err_q, tmo_q;
   logic [CNT_W-1:0]  wd_cnt;
   logic [CNT_W-1:0]  done_q;

   logic              accept, busy;
   logic              aw_hs, w_hs, aw_fin, w_fin, b_hs, ar_hs, r_hs, rsp_hs;
   logic              err_set, tmo_set;

   assign accept = cmd_valid && (state == ST_IDLE);
   assign busy   = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                   (state == ST_RD_REQ) || (state == ST_RD_DATA);
   assign aw_hs  = awvalid_q && axil.m_awready;
   assign w_hs   = wvalid_q  && axil.m_wready;
   // A channel counts as finished once its valid has already dropped or it handshakes now.
   assign aw_fin = !awvalid_q || axil.m_awready;
   assign w_fin  = !wvalid_q  || axil.m_wready;
   assign b_hs   = bready_q  && axil.m_bvalid;
   assign ar_hs  = arvalid_q && axil.m_arready;
   assign r_hs   = rready_q  && axil.m_rvalid;
   assign rsp_hs = rsp_valid_q && rsp_ready;

   assign err_set = (b_hs && (axil.m_bresp != 2'b00)) || (r_hs && (axil.m_rresp != 2'b00));
   assign tmo_set = busy && (wd_cnt == WD_LAST);

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (cmd_valid) state_nxt = cmd_wr ? ST_WR_REQ : ST_RD_REQ;
         ST_WR_REQ:  if (aw_fin && w_fin) state_nxt = ST_WR_RESP;
         ST_WR_RESP: if (b_hs) state_nxt = ST_RSP;
         ST_RD_REQ:  if (ar_hs) state_nxt = ST_RD_DATA;
         ST_RD_DATA: if (r_hs) state_nxt = ST_RSP;
         ST_RSP:     if (rsp_hs) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the handshake flops; every bus output stays registered.
   always_comb begin
      cmd_ready   = (state == ST_IDLE);
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_wr) begin
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end
            if (cmd_valid && !cmd_wr) arvalid_d = 1'b1;
         end
         ST_WR_REQ: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (aw_fin && w_fin) bready_d = 1'b1;
         end
         ST_WR_RESP: begin
            if (b_hs) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
            end
         end
         ST_RD_REQ: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
            end
         end
         ST_RD_DATA: begin
            if (r_hs) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
            end
         end
         ST_RSP: begin
            if (rsp_hs) rsp_valid_d = 1'b0;
         end
         default: begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         araddr_q    <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         rsp_wr_q    <= 1'b0;
         err_q       <= 1'b0;
         tmo_q       <= 1'b0;
         wd_cnt      <= '0;
         done_q      <= '0;
      end else begin
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         if (accept && cmd_wr) begin
            awaddr_q <= cmd_addr;
            wdata_q  <= cmd_wdata;
            wstrb_q  <= cmd_wstrb;
         end
         if (accept && !cmd_wr) araddr_q <= cmd_addr;
         if (accept) rsp_wr_q <= cmd_wr;
         if (b_hs) begin
            rsp_rdata_q <= '0;
            rsp_resp_q  <= axil.m_bresp;
         end
         if (r_hs) begin
            rsp_rdata_q <= axil.m_rdata;
            rsp_resp_q  <= axil.m_rresp;
         end
         // Set beats clear when both land on the same edge.
         err_q <= err_set || (err_q && !sticky_clr);
         tmo_q <= tmo_set || (tmo_q && !sticky_clr);
         if (accept) begin
            wd_cnt <= '0;
         end else if (busy && (wd_cnt != WD_LIMIT)) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
         end
         if (rsp_hs) done_q <= done_q + CNT_W'(1);
      end
   end

   assign axil.m_awvalid = awvalid_q;
   assign axil.m_awaddr  = awaddr_q;
   assign axil.m_wvalid  = wvalid_q;
   assign axil.m_wdata   = wdata_q;
   assign axil.m_wstrb   = wstrb_q;
   assign axil.m_bready  = bready_q;
   assign axil.m_arvalid = arvalid_q;
   assign axil.m_araddr  = araddr_q;
   assign axil.m_rready  = rready_q;

   assign rsp_valid      = rsp_valid_q;
   assign rsp_rdata      = rsp_rdata_q;
   assign rsp_resp       = rsp_resp_q;
   assign rsp_wr         = rsp_wr_q;
   assign err_sticky     = err_q;
   assign timeout_sticky = tmo_q;
   assign done_cnt       = done_q;

endmodule

// File: tb/tb_cl_ocl_axil_master.sv
// Bench for cl_ocl_axil_master: a scheduled AXI-Lite slave and consumer, with expected
// timing and status derived from per-transaction stall counts.
module tb_cl_ocl_axil_master;
   localparam int T  = 8;
   localparam int CW = 4;

   logic          clk_main_a0 = 1'b0;
   logic          rst_main_n  = 1'b1;
   logic          cmd_valid = 1'b0, cmd_wr = 1'b0;
   logic [31:0]   cmd_addr = '0, cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          cmd_ready;
   logic          rsp_valid, rsp_wr;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic          timeout_sticky, err_sticky;
   logic          sticky_clr = 1'b0;
   logic [CW-1:0] done_cnt;

   cl_ocl_axil_master_if axil ();

   cl_ocl_axil_master #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
      .clk_main_a0   (clk_main_a0),
      .rst_main_n    (rst_main_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_wr        (cmd_wr),
      .cmd_addr      (cmd_addr),
      .cmd_wdata     (cmd_wdata),
      .cmd_wstrb     (cmd_wstrb),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_resp      (rsp_resp),
      .rsp_wr        (rsp_wr),
      .axil          (axil),
      .timeout_sticky(timeout_sticky),
      .err_sticky    (err_sticky),
      .sticky_clr    (sticky_clr),
      .done_cnt      (done_cnt)
   );

   always #5 clk_main_a0 = ~clk_main_a0;

   int total = 0;
   int bad   = 0;
   bit m_err = 1'b0;
   bit m_to  = 1'b0;
   int m_done = 0;

   task automatic slave_idle();
      axil.m_awready = 1'b0; axil.m_wready = 1'b0;
      axil.m_bvalid  = 1'b0; axil.m_bresp  = 2'b00;
      axil.m_arready = 1'b0; axil.m_rvalid = 1'b0;
      axil.m_rdata   = '0;   axil.m_rresp  = 2'b00;
   endtask

   // One transaction driven on a fixed schedule: address ready after d_a stalls, W ready
   // after d_w stalls, response d_b cycles after the request phase, consumer waits rsp_d.
   task automatic run_txn(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int d_a, input int d_w, input int d_b,
                          input logic [1:0] resp, input logic [31:0] rdata,
                          input int rsp_d, input int clr_edge);
      int a_e, w_e, hs, e, c;
      logic [8:0]  got, exp;
      logic [34:0] rgot, rexp;
      a_e = 1 + d_a;
      w_e = wr ? 1 + d_w : 0;
      hs  = (a_e > w_e) ? a_e : w_e;
      e   = hs + 1 + d_b;
      c   = e + 1 + rsp_d;
      slave_idle();
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
      rsp_ready = 1'b0; sticky_clr = 1'b0;
      @(negedge clk_main_a0);
      total++;
      if (cmd_ready !== 1'b1) begin
         bad++; $display("FAIL %s accept: cmd_ready=%b want 1", tag, cmd_ready);
      end
      @(posedge clk_main_a0); #1;
      for (int k = 1; k <= c; k++) begin
         cmd_valid = 1'($urandom_range(0, 1)); cmd_wr = 1'($urandom);
         cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
         if (wr) begin
            axil.m_awready = (k >= a_e); axil.m_wready = (k >= w_e);
            axil.m_bvalid  = (k == e);   axil.m_bresp  = (k == e) ? resp : 2'($urandom);
            axil.m_arready = 1'($urandom); axil.m_rvalid = 1'b1;
            axil.m_rdata   = $urandom;     axil.m_rresp  = 2'($urandom);
         end else begin
            axil.m_arready = (k >= a_e); axil.m_rvalid = (k == e);
            axil.m_rdata   = (k == e) ? rdata : $urandom;
            axil.m_rresp   = (k == e) ? resp : 2'($urandom);
            axil.m_awready = 1'($urandom); axil.m_wready = 1'($urandom);
            axil.m_bvalid  = 1'b1;         axil.m_bresp  = 2'($urandom);
         end
         rsp_ready  = (k == c) || (k <= e && $urandom_range(0, 1) == 1);
         sticky_clr = (k == clr_edge);
         @(negedge clk_main_a0);
         exp = {1'b0, wr && k <= a_e, wr && k <= w_e, wr && k > hs && k <= e,
                !wr && k <= a_e, !wr && k > hs && k <= e, k > e, m_err, m_to};
         got = {cmd_ready, axil.m_awvalid, axil.m_wvalid, axil.m_bready,
                axil.m_arvalid, axil.m_rready, rsp_valid, err_sticky, timeout_sticky};
         total++;
         if (got !== exp) begin
            bad++; $display("FAIL %s ctl k=%0d {crdy,aw,w,b,ar,r,rsp,err,tmo} got=%b want=%b", tag, k, got, exp);
         end
         if (k <= a_e) begin
            total++;
            if ((wr ? axil.m_awaddr : axil.m_araddr) !== addr) begin
               bad++; $display("FAIL %s addr k=%0d got=%h want=%h", tag, k,
                               wr ? axil.m_awaddr : axil.m_araddr, addr);
            end
         end
         if (wr && k <= w_e) begin
            total++;
            if ({axil.m_wdata, axil.m_wstrb} !== {data, strb}) begin
               bad++; $display("FAIL %s wdata k=%0d got=%h/%h want=%h/%h", tag, k,
                               axil.m_wdata, axil.m_wstrb, data, strb);
            end
         end
         if (k > e) begin
            rgot = {rsp_rdata, rsp_resp, rsp_wr};
            rexp = {wr ? 32'h0 : rdata, resp, wr};
            total++;
            if (rgot !== rexp) begin
               bad++; $display("FAIL %s rsp k=%0d {rdata,resp,wr} got=%h want=%h", tag, k, rgot, rexp);
            end
         end
         total++;
         if (done_cnt !== CW'(m_done)) begin
            bad++; $display("FAIL %s done_cnt k=%0d got=%0d want=%0d", tag, k, done_cnt, CW'(m_done));
         end
         @(posedge clk_main_a0);
         m_err = (k == e && resp != 2'b00) || (m_err && k != clr_edge);
         m_to  = (k == T && e >= T) || (m_to && k != clr_edge);
         if (k == c) m_done++;
         #1;
      end
      cmd_valid = 1'b0; rsp_ready = 1'b0; sticky_clr = 1'b0;
      slave_idle();
      total++;
      if ({cmd_ready, rsp_valid, done_cnt} !== {2'b10, CW'(m_done)}) begin
         bad++; $display("FAIL %s after: crdy=%b rsp_valid=%b done=%0d want 1/0/%0d", tag,
                         cmd_ready, rsp_valid, done_cnt, CW'(m_done));
      end
   endtask

   task automatic test_reset();
      slave_idle();
      #1 rst_main_n = 1'b0;
      #2;
      total++;
      if ({cmd_ready, rsp_valid, axil.m_awvalid, axil.m_wvalid, axil.m_bready, axil.m_arvalid,
           axil.m_rready, err_sticky, timeout_sticky, done_cnt} !== {1'b1, 8'h00, {CW{1'b0}}}) begin
         bad++; $display("FAIL reset ctl: crdy=%b rsp=%b aw=%b w=%b b=%b ar=%b r=%b err=%b tmo=%b done=%0d",
                         cmd_ready, rsp_valid, axil.m_awvalid, axil.m_wvalid, axil.m_bready,
                         axil.m_arvalid, axil.m_rready, err_sticky, timeout_sticky, done_cnt);
      end
      repeat (2) @(posedge clk_main_a0);
      #1 rst_main_n = 1'b1;
      @(posedge clk_main_a0); #1;
   endtask

   task automatic test_write_basic();
      run_txn("wr_basic", 1'b1, 32'h500, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 0, -1);
   endtask

   task automatic test_write_w_delay();
      run_txn("wr_wdelay", 1'b1, 32'h504, 32'h12345678, 4'h3, 0, 5, 0, 2'b00, 32'h0, 0, -1);
   endtask

   task automatic test_read_err();
      run_txn("rd_err", 1'b0, 32'h720, 32'h0, 4'h0, 0, 0, 3, 2'b10, 32'hFEEDC0DE, 0, -1);
   endtask

   task automatic test_sticky_clr();
      sticky_clr = 1'b1;
      @(negedge clk_main_a0);
      total++;
      if ({err_sticky, timeout_sticky} !== {m_err, m_to} || m_err != 1'b1) begin
         bad++; $display("FAIL sticky_pre err=%b tmo=%b want %b/%b (err must be 1)",
                         err_sticky, timeout_sticky, m_err, m_to);
      end
      @(posedge clk_main_a0); #1;
      sticky_clr = 1'b0; m_err = 1'b0; m_to = 1'b0;
      total++;
      if ({err_sticky, timeout_sticky} !== 2'b00) begin
         bad++; $display("FAIL sticky_clr err=%b tmo=%b want 0/0", err_sticky, timeout_sticky);
      end
   endtask

   task automatic test_timeout();
      run_txn("timeout", 1'b0, 32'h7F0, 32'h0, 4'h0, 20, 0, 1, 2'b00, 32'hA5A5_0001, 0, -1);
   endtask

   task automatic test_back_to_back();
      run_txn("rsp_bp", 1'b1, 32'h800, 32'hCAFEF00D, 4'hC, 1, 0, 2, 2'b00, 32'h0, 10, -1);
      run_txn("b2b_rd", 1'b0, 32'h804, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h0BAD_F00D, 0, -1);
   endtask

   task automatic test_set_wins();
      run_txn("set_wins", 1'b0, 32'h900, 32'h0, 4'h0, 1, 0, 2, 2'b01, 32'h1111_2222, 1, 5);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         bit          wr;
         int          d_a, d_w, d_b, rsp_d, clr, gap;
         logic [1:0]  resp;
         wr    = 1'($urandom);
         d_a   = $urandom_range(0, 3) + (($urandom_range(0, 5) == 0) ? 6 : 0);
         d_w   = $urandom_range(0, 3);
         d_b   = $urandom_range(0, 3);
         rsp_d = $urandom_range(0, 3);
         resp  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
         clr   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : -1;
         gap   = $urandom_range(0, 2);
         run_txn("random", wr, $urandom, $urandom, 4'($urandom), d_a, d_w, d_b, resp,
                 $urandom, rsp_d, clr);
         repeat (gap) begin
            @(posedge clk_main_a0); #1;
         end
      end
   endtask

   task automatic test_reset_mid();
      slave_idle();
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h600; cmd_wdata = 32'h55AA_33CC; cmd_wstrb = 4'hF;
      axil.m_awready = 1'b1; axil.m_wready = 1'b1;
      @(posedge clk_main_a0); #1;
      cmd_valid = 1'b0;
      @(posedge clk_main_a0); #1;
      total++;
      if (axil.m_bready !== 1'b1) begin
         bad++; $display("FAIL rst_mid pre: m_bready=%b want 1", axil.m_bready);
      end
      #2 rst_main_n = 1'b0;
      #1;
      total++;
      if ({axil.m_awvalid, axil.m_wvalid, axil.m_bready, axil.m_arvalid, axil.m_rready,
           rsp_valid, err_sticky, timeout_sticky, done_cnt} !== {8'h00, {CW{1'b0}}}) begin
         bad++; $display("FAIL rst_mid ctl aw=%b w=%b b=%b ar=%b r=%b rsp=%b err=%b tmo=%b done=%0d want all 0",
                         axil.m_awvalid, axil.m_wvalid, axil.m_bready, axil.m_arvalid,
                         axil.m_rready, rsp_valid, err_sticky, timeout_sticky, done_cnt);
      end
      total++;
      if ({axil.m_awaddr, axil.m_wdata, axil.m_wstrb, axil.m_araddr, rsp_rdata, rsp_resp,
           rsp_wr, cmd_ready} !== {134'h0, 1'b1}) begin
         bad++; $display("FAIL rst_mid data awaddr=%h wdata=%h wstrb=%h araddr=%h rdata=%h resp=%b wr=%b crdy=%b",
                         axil.m_awaddr, axil.m_wdata, axil.m_wstrb, axil.m_araddr, rsp_rdata,
                         rsp_resp, rsp_wr, cmd_ready);
      end
      m_err = 1'b0; m_to = 1'b0; m_done = 0;
      slave_idle();
      @(posedge clk_main_a0); #1;
      rst_main_n = 1'b1;
      @(posedge clk_main_a0); #1;
      run_txn("rst_mid_rd", 1'b0, 32'h604, 32'h0, 4'h0, 0, 0, 1, 2'b00, 32'h0DDB_A115, 0, -1);
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_write_w_delay();
      test_read_err();
      test_sticky_clr();
      test_timeout();
      test_back_to_back();
      test_set_wins();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit reached: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
endmodule

// File: doc/cl_ocl_axil_master.md
Name: cl_ocl_axil_master

Overview:
- Single-outstanding AXI-Lite initiator. Converts a simple command/response handshake into 32-bit single-beat AXI-Lite reads and writes.
- Drives register-mapped AXI-Lite slaves on the CL side: the BAR0 register block, or a peer CL block behind an AXI-Lite register slice.
- Provides a per-transaction watchdog and sticky error status for driver-visible debug.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles from command acceptance to completion before the timeout is flagged; legal range 2..65535.
- CNT_W, 16: width of the watchdog and completed-transaction counters.

Ports:
- clk_main_a0  in  1  clock
- rst_main_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP as returned by the slave
- rsp_wr  out  1  echo of cmd_wr
- m_awvalid/m_awready  out/in  1/1  write address handshake
- m_awaddr  out  32  write address
- m_wvalid/m_wready  out/in  1/1  write data handshake
- m_wdata  out  32  write data
- m_wstrb  out  4  write strobes
- m_bvalid/m_bready  in/out  1/1  write response handshake
- m_bresp  in  2  write response
- m_arvalid/m_arready  out/in  1/1  read address handshake
- m_araddr  out  32  read address
- m_rvalid/m_rready  in/out  1/1  read data handshake
- m_rdata  in  32  read data
- m_rresp  in  2  read response
- timeout_sticky  out  1  set on watchdog expiry
- err_sticky  out  1  set on any response with resp!=0
- sticky_clr  in  1  clears both sticky bits; set wins over clear in the same cycle
- done_cnt  out  CNT_W  count of completed transactions; wraps at 2^CNT_W

Behaviour:
- Reset (asynchronous, rst_main_n=0): state=IDLE; all m_*valid, m_bready, m_rready, rsp_valid, stickies, done_cnt, rsp_* and m_*addr/data/strb = 0.
- All outputs are flop-driven except cmd_ready, which is (state==IDLE). There is no combinational path from any AXI input to any AXI output.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: on cmd_valid, capture addr/data/strb/wr.
  - Write: go to WR_REQ with m_awvalid=m_wvalid=1 in the next cycle.
  - Read: go to RD_REQ with m_arvalid=1 in the next cycle.
- WR_REQ: AW and W are independent.
  - Each valid drops the cycle after its own ready is sampled high.
  - A valid is never deasserted before its ready, and payloads are stable while valid is high.
  - When both handshakes are done (any order, or the same cycle), go to WR_RESP with m_bready=1.
- WR_RESP: on m_bvalid&&m_bready, latch bresp, drop m_bready, go to RSP.
- RD_REQ: on m_arready, drop m_arvalid, assert m_rready, go to RD_DATA.
- RD_DATA: on m_rvalid&&m_rready, latch rdata/rresp, drop m_rready, go to RSP.
- RSP: rsp_valid=1, with rsp_* stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid->0, done_cnt+1, state->IDLE.
  - cmd_ready rises the following cycle, so back-to-back command spacing is at least one IDLE cycle.
- Minimum latency with always-ready slave and consumer:
  - Write: cmd accept at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
- Watchdog:
  - Counter clears on cmd accept and increments in WR_REQ/WR_RESP/RD_REQ/RD_DATA.
  - When it reaches TIMEOUT_CYCLES, set timeout_sticky once.
  - The transaction is NOT aborted: handshakes remain pending, staying AXI-compliant.
  - The counter saturates; it does not count in RSP.
- err_sticky is set in the cycle the response is latched if resp!=0.
- Unexpected m_bvalid or m_rvalid outside its wait state is ignored; the corresponding ready stays 0.
- cmd_* is sampled only on accept. Changes while busy have no effect.
- Reset mid-transaction drops all valids/readies immediately. The slave must be reset by the same reset.

Test Plan:
- Write addr=0x500 data=0xDEADBEEF strb=0xF, slave readies always high -> m_awaddr=0x500, m_wdata=0xDEADBEEF at cycle 1; rsp_valid cycle 3 with rsp_resp=0, rsp_rdata=0; done_cnt=1.
- Write with m_wready delayed 5 cycles after m_awready -> m_awvalid high 1 cycle, m_wvalid high 6 cycles; m_bready rises only after the W handshake; single response.
- Read 0x720, slave returns rdata=0xFEEDC0DE rresp=2'b10 after 3 stall cycles -> rsp_rdata=0xFEEDC0DE, rsp_resp=2, err_sticky=1; sticky_clr pulse -> 0.
- TIMEOUT_CYCLES=8, m_arready held 0 for 20 cycles -> timeout_sticky=1 at cycle 8 after accept, m_arvalid still 1; then m_arready=1 and the read completes normally.
- rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0 throughout; after consume, the next cmd is accepted 1 cycle later.
- rst_main_n asserted while in WR_RESP -> all outputs 0 asynchronously; after release, the first read completes with done_cnt=1.
